// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the two-master RAM bus arbiter.
// Holds the FSM state encoding, default bus geometry and master index constants.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccWr = 2'd1,
        StAccRd = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DEF_ADDR_WIDTH   = 8;
    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_READ_LATENCY = 2;
    localparam logic [7:0]  DEF_PARK_ADDR    = 8'hFF;

    localparam int unsigned MST_A = 0;
    localparam int unsigned MST_B = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker: one-hot grant from req, pointer advances on accept.
// ARB_FIXED_PRIORITY_EN turns it into a fixed A-over-B priority picker with no pointer.
module rr_arb2
    import bus_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

`ifdef ARB_FIXED_PRIORITY_EN

    logic unused_fixed;
    assign unused_fixed = ^{clk, rst_n, accept};

    always_comb begin
        gnt = 2'b00;
        if (req[MST_A]) begin
            gnt[MST_A] = 1'b1;
        end else if (req[MST_B]) begin
            gnt[MST_B] = 1'b1;
        end
    end

`else

    // Set when B received the most recent grant; resets set so A wins first.
    logic last_b_q;

    always_comb begin
        gnt = 2'b00;
        if (req[MST_A] && req[MST_B]) begin
            if (last_b_q) begin
                gnt[MST_A] = 1'b1;
            end else begin
                gnt[MST_B] = 1'b1;
            end
        end else if (req[MST_A]) begin
            gnt[MST_A] = 1'b1;
        end else if (req[MST_B]) begin
            gnt[MST_B] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q <= 1'b1;
        end else if (accept && (gnt != 2'b00)) begin
            last_b_q <= gnt[MST_B];
        end
    end

`endif

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter and access sequencer for the shared RAM bus (registered read, parked idle).
// Define ARB_FIXED_PRIORITY_EN for fixed A-over-B priority instead of round-robin.
module ram_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned            DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned            READ_LATENCY = DEF_READ_LATENCY,
    parameter logic [ADDR_WIDTH-1:0]  PARK_ADDR    = DEF_PARK_ADDR
) (
    input  logic                  CLK,
    input  logic                  RESET,

    input  logic                  REQ_A,
    input  logic                  WE_A,
    input  logic [ADDR_WIDTH-1:0] ADDR_A,
    input  logic [DATA_WIDTH-1:0] WDATA_A,
    output logic                  ACK_A,
    output logic [DATA_WIDTH-1:0] RDATA_A,

    input  logic                  REQ_B,
    input  logic                  WE_B,
    input  logic [ADDR_WIDTH-1:0] ADDR_B,
    input  logic [DATA_WIDTH-1:0] WDATA_B,
    output logic                  ACK_B,
    output logic [DATA_WIDTH-1:0] RDATA_B,

    output logic                  GNT_A,
    output logic                  GNT_B,

    output logic [ADDR_WIDTH-1:0] BUS_ADDR,
    output logic                  BUS_WE,
    inout  wire  [DATA_WIDTH-1:0] BUS_DATA
);

    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic                  bus_we_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  gnt_a_q;
    logic                  gnt_b_q;
    logic                  ack_a_q;
    logic                  ack_b_q;
    logic [DATA_WIDTH-1:0] rdata_a_q;
    logic [DATA_WIDTH-1:0] rdata_b_q;

    logic [1:0]            arb_req;
    logic [1:0]            arb_gnt;
    logic                  arb_accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign arb_req[MST_A] = REQ_A;
    assign arb_req[MST_B] = REQ_B;
    assign arb_accept     = (state_q == StIdle);

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst_n  (RESET),
        .req    (arb_req),
        .accept (arb_accept),
        .gnt    (arb_gnt)
    );

    always_comb begin
        sel_we    = WE_A;
        sel_addr  = ADDR_A;
        sel_wdata = WDATA_A;
        if (arb_gnt[MST_B]) begin
            sel_we    = WE_B;
            sel_addr  = ADDR_B;
            sel_wdata = WDATA_B;
        end
    end

    // Bus outputs are loaded one edge early so they are registered in the access state itself.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            bus_addr_q  <= PARK_ADDR;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            cnt_q       <= '0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    bus_addr_q <= PARK_ADDR;
                    bus_we_q   <= 1'b0;
                    gnt_a_q    <= 1'b0;
                    gnt_b_q    <= 1'b0;
                    if (arb_gnt != 2'b00) begin
                        gnt_a_q    <= arb_gnt[MST_A];
                        gnt_b_q    <= arb_gnt[MST_B];
                        bus_addr_q <= sel_addr;
                        if (sel_we) begin
                            bus_we_q    <= 1'b1;
                            bus_wdata_q <= sel_wdata;
                            state_q     <= StAccWr;
                        end else begin
                            cnt_q   <= CNT_W'(READ_LATENCY - 1);
                            state_q <= StAccRd;
                        end
                    end
                end
                StAccWr: begin
                    bus_addr_q <= PARK_ADDR;
                    bus_we_q   <= 1'b0;
                    ack_a_q    <= gnt_a_q;
                    ack_b_q    <= gnt_b_q;
                    state_q    <= StDone;
                end
                StAccRd: begin
                    if (cnt_q == '0) begin
                        if (gnt_a_q) begin
                            rdata_a_q <= BUS_DATA;
                        end
                        if (gnt_b_q) begin
                            rdata_b_q <= BUS_DATA;
                        end
                        bus_addr_q <= PARK_ADDR;
                        ack_a_q    <= gnt_a_q;
                        ack_b_q    <= gnt_b_q;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    gnt_a_q <= 1'b0;
                    gnt_b_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign BUS_ADDR = bus_addr_q;
    assign BUS_WE   = bus_we_q;
    assign BUS_DATA = bus_we_q ? bus_wdata_q : {DATA_WIDTH{1'bz}};
    assign GNT_A    = gnt_a_q;
    assign GNT_B    = gnt_b_q;
    assign ACK_A    = ack_a_q;
    assign ACK_B    = ack_b_q;
    assign RDATA_A  = rdata_a_q;
    assign RDATA_B  = rdata_b_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter with a 128-byte registered-read RAM at base 0 (Mem[i]=i).
// Expected order, latency and data come from a transaction-level model of arbitration and memory.
module tb_ram_bus_arbiter;

    localparam int unsigned RL = 2;

    logic       CLK;
    logic       RESET;
    logic       REQ_A, WE_A, REQ_B, WE_B;
    logic [7:0] ADDR_A, WDATA_A, ADDR_B, WDATA_B;
    logic       ACK_A, ACK_B, GNT_A, GNT_B, BUS_WE;
    logic [7:0] RDATA_A, RDATA_B, BUS_ADDR;
    wire  [7:0] BUS_DATA;

    int compared = 0;
    int mismatched = 0;

    ram_bus_arbiter #(
        .ADDR_WIDTH   (8),
        .DATA_WIDTH   (8),
        .READ_LATENCY (RL),
        .PARK_ADDR    (8'hFF)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ_A    (REQ_A),
        .WE_A     (WE_A),
        .ADDR_A   (ADDR_A),
        .WDATA_A  (WDATA_A),
        .ACK_A    (ACK_A),
        .RDATA_A  (RDATA_A),
        .REQ_B    (REQ_B),
        .WE_B     (WE_B),
        .ADDR_B   (ADDR_B),
        .WDATA_B  (WDATA_B),
        .ACK_B    (ACK_B),
        .RDATA_B  (RDATA_B),
        .GNT_A    (GNT_A),
        .GNT_B    (GNT_B),
        .BUS_ADDR (BUS_ADDR),
        .BUS_WE   (BUS_WE),
        .BUS_DATA (BUS_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM slave: registered read with registered drive enable, synchronous write.
    logic [7:0] mem [128];
    logic [7:0] ram_q;
    logic       ram_en;
    always @(posedge CLK) begin
        if (BUS_WE && BUS_ADDR < 8'd128) mem[BUS_ADDR[6:0]] <= BUS_DATA;
        ram_en <= !BUS_WE && (BUS_ADDR < 8'd128);
        ram_q  <= mem[BUS_ADDR[6:0]];
    end
    assign BUS_DATA = ram_en ? ram_q : 8'hzz;

    // Reference model state.
    logic [7:0] ref_mem [128];
    bit         last_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle bus invariants.
    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            check("gnt_onehot", {31'd0, GNT_A & GNT_B}, 32'd0);
            check("no_contention", {31'd0, BUS_WE & ram_en}, 32'd0);
            if (!GNT_A && !GNT_B) check("parked_idle", {23'd0, BUS_WE, BUS_ADDR}, 32'h0FF);
        end
    end

    task automatic model_access(input bit w, input logic [7:0] a, input logic [7:0] d,
                                output logic [7:0] rd);
        rd = 8'h00;
        if (a < 8'd128) begin
            if (w) ref_mem[a[6:0]] = d;
            rd = ref_mem[a[6:0]];
        end
    endtask

    // Raise the given requests together and serve them until both have been acknowledged.
    task automatic run_pair(input bit va, input bit wa, input logic [7:0] aa, input logic [7:0] da,
                            input bit vb, input bit wb, input logic [7:0] ab, input logic [7:0] db);
        bit         a_first, done_a, done_b, drop_a, drop_b;
        logic [7:0] exp_a, exp_b;
        int         k, first_obs;
        exp_a = 8'h00;
        exp_b = 8'h00;
`ifdef ARB_FIXED_PRIORITY_EN
        a_first = va;
`else
        a_first = (va && vb) ? last_b : va;
`endif
        if (a_first) begin
            if (va) model_access(wa, aa, da, exp_a);
            if (vb) model_access(wb, ab, db, exp_b);
        end else begin
            if (vb) model_access(wb, ab, db, exp_b);
            if (va) model_access(wa, aa, da, exp_a);
        end
        last_b = (va && vb) ? a_first : vb;

        REQ_A = va; WE_A = wa; ADDR_A = aa; WDATA_A = da;
        REQ_B = vb; WE_B = wb; ADDR_B = ab; WDATA_B = db;
        done_a = !va;
        done_b = !vb;
        first_obs = -1;
        k = 0;
        while (!(done_a && done_b) && k < 40) begin
            @(negedge CLK);
            drop_a = 1'b0;
            drop_b = 1'b0;
            if (ACK_A) begin
                check("ack_a_expected", {31'd0, va && !done_a}, 32'd1);
                check("gnt_a_with_ack", {31'd0, GNT_A}, 32'd1);
                if (!wa && aa < 8'd128) check("rdata_a", {24'd0, RDATA_A}, {24'd0, exp_a});
                if (!vb) check("latency_a", k + 1, wa ? 3 : 2 + RL);
                if (first_obs < 0) first_obs = 0;
                done_a = 1'b1;
                drop_a = 1'b1;
            end
            if (ACK_B) begin
                check("ack_b_expected", {31'd0, vb && !done_b}, 32'd1);
                check("gnt_b_with_ack", {31'd0, GNT_B}, 32'd1);
                if (!wb && ab < 8'd128) check("rdata_b", {24'd0, RDATA_B}, {24'd0, exp_b});
                if (!va) check("latency_b", k + 1, wb ? 3 : 2 + RL);
                if (first_obs < 0) first_obs = 1;
                done_b = 1'b1;
                drop_b = 1'b1;
            end
            k++;
            if (drop_a || drop_b) begin
                @(posedge CLK);
                #1;
                if (drop_a) REQ_A = 1'b0;
                if (drop_b) REQ_B = 1'b0;
            end
        end
        if (!(done_a && done_b)) begin
            check("ack_timeout", {30'd0, done_a, done_b}, {30'd0, va, vb});
            REQ_A = 1'b0;
            REQ_B = 1'b0;
            @(posedge CLK);
            #1;
        end else if (va && vb) begin
            check("grant_order", first_obs, a_first ? 0 : 1);
        end
    endtask

    initial begin
        bit         va, vb;
        logic [7:0] aa, ab, da, db;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'(i);
            ref_mem[i] = 8'(i);
        end
        ram_en = 1'b0;
        ram_q = 8'h00;
        REQ_A = 0; WE_A = 0; ADDR_A = 0; WDATA_A = 0;
        REQ_B = 0; WE_B = 0; ADDR_B = 0; WDATA_B = 0;
        RESET = 1'b0;
        last_b = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_bus_addr", {24'd0, BUS_ADDR}, 32'hFF);
        check("rst_bus_we", {31'd0, BUS_WE}, 32'd0);
        check("rst_gnt_ack", {28'd0, GNT_A, GNT_B, ACK_A, ACK_B}, 32'd0);
        check("rst_rdata", {16'd0, RDATA_A, RDATA_B}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Simultaneous reads right after reset: A first, then B.
        run_pair(1, 0, 8'h05, 8'h00, 1, 0, 8'h06, 8'h00);
        // Write then read back through A.
        run_pair(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
        run_pair(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        // Read immediately followed by write.
        run_pair(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        run_pair(1, 1, 8'h21, 8'h3C, 0, 0, 8'h00, 8'h00);
        check("mem_21", {24'd0, mem[8'h21]}, 32'h3C);
        // Back-to-back contention: grants alternate.
        for (int i = 0; i < 4; i++) begin
            run_pair(1, 1, 8'(8'h30 + i), 8'(8'hC0 + i), 1, 1, 8'(8'h40 + i), 8'(8'hD0 + i));
        end
        // Unmapped read completes normally.
        run_pair(1, 0, 8'h90, 8'h00, 0, 0, 8'h00, 8'h00);
        @(negedge CLK);
        check("unmapped_back_idle", {30'd0, GNT_A, GNT_B}, 32'd0);
        @(posedge CLK);
        #1;

        // Reset in the middle of a read.
        REQ_A = 1'b1; WE_A = 1'b0; ADDR_A = 8'h50;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check("midrd_rst_bus", {23'd0, BUS_WE, BUS_ADDR}, 32'h0FF);
        check("midrd_rst_gnt_ack", {28'd0, GNT_A, GNT_B, ACK_A, ACK_B}, 32'd0);
        check("midrd_rst_rdata", {16'd0, RDATA_A, RDATA_B}, 32'd0);
        REQ_A = 1'b0;
        last_b = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("no_ack_after_rst", {30'd0, ACK_A, ACK_B}, 32'd0);
        end
        @(posedge CLK);
        #1;
        run_pair(1, 0, 8'h07, 8'h00, 0, 0, 8'h00, 8'h00);

        // Randomized mixed traffic.
        for (int i = 0; i < 24; i++) begin
            va = 1'($urandom);
            vb = 1'($urandom);
            if (!va && !vb) va = 1'b1;
            aa = 8'($urandom_range(0, 127));
            ab = 8'($urandom_range(0, 127));
            da = 8'($urandom);
            db = 8'($urandom);
            run_pair(va, 1'($urandom), aa, da, vb, 1'($urandom), ab, db);
        end

        repeat (2) @(posedge CLK);
        for (int i = 0; i < 128; i++) begin
            check("final_mem", {24'd0, mem[i]}, {24'd0, ref_mem[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
